// File: rtl/ssd1306_spi_sequencer_pkg.sv
// Shared types and constants for the SSD1306 SPI sequencer.
package ssd1306_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    RES_LOW  = 3'd0,
    RES_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    START    = 3'd4,
    SHIFT    = 3'd5,
    NEXT     = 3'd6,
    HOLD     = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic                  dc;
    logic [SPI_BYTE_W-1:0] data;
  } spi_entry_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ssd1306_spi_sequencer_byte_fifo.sv
// Single-clock show-ahead FIFO; full/empty are decoded from the occupancy counter.
module byte_fifo
  import ssd1306_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = spi_entry_t
) (
  input  logic                       clk_in,
  input  logic                       resetn_in,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wdata,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == {LVL_W{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign rdata  = mem_q[rd_ptr_q];
  assign level  = level_q;

  // Occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_s && pop_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sequencer.sv
// SSD1306 SPI sequencer: OLED reset pulse, then drains {dc, byte} entries through
// an external byte shift register while framing chip select and D/C.
module ssd1306_spi_sequencer
  import ssd1306_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RES_CYCLES = 16,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic                       clk_in,
  input  logic                       resetn_in,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SPI_BYTE_W-1:0]      wr_data,
  input  logic                       wr_dc,
  output logic                       sr_start,
  output logic [SPI_BYTE_W-1:0]      sr_data,
  input  logic                       sr_ready,
  output logic                       oled_cs_n,
  output logic                       oled_dc,
  output logic                       oled_res_n,
  output logic                       busy,
  output logic                       init_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int CNT_MAX = max3(RES_CYCLES, CS_SETUP, CS_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sr_start_q, oled_cs_n_q, oled_dc_q, oled_res_n_q, busy_q, init_done_q;
  logic [SPI_BYTE_W-1:0] sr_data_q;
  spi_entry_t            wr_entry_s, head_s;
  logic                  full_s, empty_s, pop_s, wr_accept_s, dc_load_s, nonempty_next_s;
  logic [LVL_W-1:0]      level_s;

  assign wr_entry_s  = '{dc: wr_dc, data: wr_data};
  assign wr_accept_s = wr_valid & ~full_s;

  byte_fifo #(.DEPTH(DEPTH), .entry_t(spi_entry_t)) u_fifo (
    .clk_in   (clk_in),
    .resetn_in(resetn_in),
    .push     (wr_accept_s),
    .pop      (pop_s),
    .wdata    (wr_entry_s),
    .rdata    (head_s),
    .full     (full_s),
    .empty    (empty_s),
    .level    (level_s)
  );

  // Sequencer next state; one shared down-counter times every wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      RES_LOW, RES_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = (state_q == RES_LOW) ? RES_WAIT : IDLE;
          cnt_d   = CNT_W'(RES_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      IDLE: begin
        if (!empty_s) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(CS_SETUP - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sr_ready) begin
          state_d = START;
        end else begin
          state_d = SETUP;
        end
      end
      START: begin
        pop_s   = 1'b1;
        state_d = SHIFT;
        cnt_d   = CNT_ONE;
      end
      SHIFT: begin
        // cnt_q=1 marks the first SHIFT cycle, where sr_ready is not yet trusted.
        if (cnt_q != CNT_ZERO) begin
          cnt_d = CNT_ZERO;
        end else if (sr_ready) begin
          state_d = empty_s ? HOLD : NEXT;
          cnt_d   = CNT_W'(CS_HOLD - 1);
        end else begin
          state_d = SHIFT;
        end
      end
      NEXT: begin
        state_d = START;
      end
      HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RES_LOW;
        cnt_d   = CNT_W'(RES_CYCLES - 1);
      end
    endcase
  end

  assign dc_load_s       = ((state_q == IDLE) && (state_d == SETUP)) || (state_d == NEXT);
  assign nonempty_next_s = wr_accept_s | (~empty_s & ~(pop_s & (level_s == LVL_ONE)));

  // State and counter registers.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q <= RES_LOW;
      cnt_q   <= CNT_W'(RES_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      oled_res_n_q <= 1'b0;
      oled_cs_n_q  <= 1'b1;
      oled_dc_q    <= 1'b0;
      sr_start_q   <= 1'b0;
      sr_data_q    <= {SPI_BYTE_W{1'b0}};
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      oled_res_n_q <= (state_d != RES_LOW);
      oled_cs_n_q  <= (state_d == RES_LOW) || (state_d == RES_WAIT) || (state_d == IDLE);
      sr_start_q   <= (state_d == START);
      init_done_q  <= init_done_q | (state_d == IDLE);
      busy_q       <= (state_d != IDLE) | nonempty_next_s;
      if (state_d == START) begin
        sr_data_q <= head_s.data;
      end else begin
        sr_data_q <= sr_data_q;
      end
      if (dc_load_s) begin
        oled_dc_q <= head_s.dc;
      end else begin
        oled_dc_q <= oled_dc_q;
      end
    end
  end

  assign wr_ready   = ~full_s;
  assign fifo_level = level_s;
  assign sr_start   = sr_start_q;
  assign sr_data    = sr_data_q;
  assign oled_cs_n  = oled_cs_n_q;
  assign oled_dc    = oled_dc_q;
  assign oled_res_n = oled_res_n_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_ssd1306_spi_sequencer.sv
// Directed bench: behavioural shift register, SPI monitor and a {dc, byte} scoreboard.
module tb_ssd1306_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready, wr_dc;
  logic [7:0] wr_data;
  logic       sr_start, sr_ready;
  logic [7:0] sr_data;
  logic       oled_cs_n, oled_dc, oled_res_n, busy, init_done;
  logic [2:0] fifo_level;

  logic [7:0] sh;
  int         sr_cnt;
  logic       serial_out, clk_out;

  logic [8:0] sb [$];
  int         n_checks = 0, n_fail = 0;
  int         n_bytes = 0, n_starts = 0, n_cs_fall = 0, n_dc_chg = 0, cyc = 0;
  int         mon_bits = 0;
  logic [7:0] mon_sh;
  logic       mon_dc;
  logic       prev_cs = 1'b1, prev_dc = 1'b0;

  ssd1306_spi_sequencer #(.DEPTH(4), .RES_CYCLES(4), .CS_SETUP(1), .CS_HOLD(1)) dut (
    .clk_in(clk), .resetn_in(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dc(wr_dc), .sr_start(sr_start), .sr_data(sr_data),
    .sr_ready(sr_ready), .oled_cs_n(oled_cs_n), .oled_dc(oled_dc),
    .oled_res_n(oled_res_n), .busy(busy), .init_done(init_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift register model: 8 busy cycles, MSB first, reset together with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_ready <= 1'b1; sh <= 8'h00; sr_cnt <= 0;
    end else if (sr_ready) begin
      if (sr_start) begin sh <= sr_data; sr_ready <= 1'b0; sr_cnt <= 8; end
    end else begin
      sh <= {sh[6:0], 1'b0};
      sr_cnt <= sr_cnt - 1;
      if (sr_cnt == 1) sr_ready <= 1'b1;
    end
  end
  assign serial_out = sh[7];
  assign clk_out    = ~sr_ready & ~clk;

  // SPI monitor and scoreboard compare.
  always @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      mon_bits = 0;
    end else begin
      if (mon_bits == 0) mon_dc = oled_dc;
      check("cs_low_in_byte", oled_cs_n, 1'b0);
      check("dc_stable_in_byte", oled_dc, mon_dc);
      mon_sh = {mon_sh[6:0], serial_out};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        n_bytes++;
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("mon_byte", {mon_dc, mon_sh}, sb.pop_front());
      end
    end
  end

  // Continuous observations away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sr_start) begin
        n_starts++;
        check("start_when_ready", sr_ready, 1'b1);
        check("start_after_init", init_done, 1'b1);
      end
      if (prev_cs && !oled_cs_n) n_cs_fall++;
      if (prev_dc != oled_dc) n_dc_chg++;
    end
    prev_cs = oled_cs_n;
    prev_dc = oled_dc;
  end

  task automatic write_entry(input logic dc, input logic [7:0] d);
    int g = 0;
    wr_valid = 1'b1; wr_dc = dc; wr_data = d;
    while (wr_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    check("wr_timeout", g < 200, 1'b1);
    @(posedge clk);
    sb.push_back({dc, d});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl);
    int g = 0;
    while (sr_ready !== lvl && g < 100) begin @(negedge clk); g++; end
    check("ready_timeout", g < 100, 1'b1);
  endtask

  task automatic wait_start();
    int g = 0;
    while (sr_start !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    check("start_timeout", g < 100, 1'b1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 300) begin @(negedge clk); g++; end
    check("idle_timeout", g < 300, 1'b1);
  endtask

  task automatic check_reset_values();
    check("rst_res_n", oled_res_n, 1'b0);
    check("rst_cs_n", oled_cs_n, 1'b1);
    check("rst_dc", oled_dc, 1'b0);
    check("rst_start", sr_start, 1'b0);
    check("rst_sr_data", sr_data, 8'h00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_level", fifo_level, 3'd0);
  endtask

  initial begin
    int c0, d0, t_r, s0, b0, g;
    rst_n = 1'b0; wr_valid = 1'b0; wr_dc = 1'b0; wr_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values();

    // Reset sequence: 4 cycles of oled_res_n low, then 4 cycles of wait.
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("seq_res_n", oled_res_n, k >= 4);
      check("seq_init_done", init_done, k >= 8);
      check("seq_cs_n", oled_cs_n, 1'b1);
    end
    check("idle_busy", busy, 1'b0);

    // Single command byte.
    write_entry(1'b0, 8'hAF);
    check("single_cs_t1", oled_cs_n, 1'b1);
    @(negedge clk);
    check("single_cs_t2", oled_cs_n, 1'b0);
    check("single_dc_t2", oled_dc, 1'b0);
    check("single_start_t2", sr_start, 1'b0);
    @(negedge clk);
    check("single_start_t3", sr_start, 1'b1);
    check("single_data_t3", sr_data, 8'hAF);
    wait_ready(1'b0);
    wait_ready(1'b1);
    check("single_cs_ready", oled_cs_n, 1'b0);
    @(negedge clk);
    check("single_cs_hold", oled_cs_n, 1'b0);
    check("single_busy_hold", busy, 1'b1);
    @(negedge clk);
    check("single_cs_rise", oled_cs_n, 1'b1);
    check("single_busy_end", busy, 1'b0);
    check("single_bytes", n_bytes, 1);

    // Burst in one chip-select window.
    c0 = n_cs_fall; d0 = n_dc_chg;
    write_entry(1'b0, 8'h21);
    write_entry(1'b0, 8'h00);
    write_entry(1'b1, 8'h55);
    for (int b = 0; b < 2; b++) begin
      wait_ready(1'b0);
      wait_ready(1'b1);
      t_r = cyc;
      wait_start();
      check("burst_gap", cyc - t_r, 2);
    end
    wait_idle();
    check("burst_cs_windows", n_cs_fall - c0, 1);
    check("burst_dc_changes", n_dc_chg - d0, 1);
    check("burst_bytes", n_bytes, 4);

    // Fill the FIFO during the reset sequence; overflow waits for the first pop.
    @(negedge clk); rst_n = 1'b0; sb.delete();
    @(negedge clk); rst_n = 1'b1;
    write_entry(1'b0, 8'h11);
    write_entry(1'b0, 8'h22);
    write_entry(1'b1, 8'h33);
    write_entry(1'b0, 8'h44);
    check("full_level", fifo_level, 3'd4);
    check("full_wr_ready", wr_ready, 1'b0);
    check("full_in_reset_seq", init_done, 1'b0);
    wr_valid = 1'b1; wr_dc = 1'b1; wr_data = 8'h5A;
    wait_start();
    check("pop_cycle_wr_ready", wr_ready, 1'b0);
    check("pop_cycle_level", fifo_level, 3'd4);
    @(negedge clk);
    check("after_pop_level", fifo_level, 3'd3);
    check("after_pop_wr_ready", wr_ready, 1'b1);
    @(posedge clk);
    sb.push_back({1'b1, 8'h5A});
    @(negedge clk);
    wr_valid = 1'b0;
    check("refill_level", fifo_level, 3'd4);
    write_entry(1'b0, 8'hC3);
    wait_idle();
    check("fill_bytes", n_bytes, 10);
    check("fill_sb_empty", sb.size(), 0);

    // Reset in the middle of a byte.
    write_entry(1'b1, 8'h3C);
    write_entry(1'b0, 8'h99);
    wait_start();
    g = 0;
    while (mon_bits < 4 && g < 50) begin @(negedge clk); #2; g++; end
    check("midbyte_timeout", g < 50, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values();
    check("rst_sr_ready", sr_ready, 1'b1);
    sb.delete();
    s0 = n_starts; c0 = n_cs_fall; b0 = n_bytes;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_starts", n_starts - s0, 0);
    check("post_rst_cs", n_cs_fall - c0, 0);
    check("post_rst_bytes", n_bytes - b0, 0);
    check("post_rst_init", init_done, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_level", fifo_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
